// File: rtl/mult5_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult5_pkg;

  // Controller states: waiting, shift-add iterations, one-cycle result strobe.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default operand width in bits.
  localparam int DEF_WIDTH = 5;

  // Iteration counter width: must hold the value DEF_WIDTH itself,
  // because the counter reaching WIDTH is what ends RUN.
  localparam int CNT_W = $clog2(DEF_WIDTH + 1);

endpackage

// File: rtl/mult5_in_sync.sv
// Two-flop synchronizer for a bundle of pad inputs. Both stages clear on
// reset, so a request pending in the chain is dropped by a reset.
module mult5_in_sync #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two-stage capture of the asynchronous pad values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mult5_seq_core.sv
// Sequential shift-add unsigned multiplier, one partial product per cycle.
//
// Optional feature macro: MULT5_INPUT_SYNC_EN -- when defined, start_i, a_i
// and b_i pass through a two-flop synchronizer (mult5_in_sync) first, and
// every input-to-done latency grows by two cycles.
//
// Request/response protocol: start_i is a single-cycle request with no
// ready; it is accepted at any edge where the core is in IDLE or DONE (a_i
// and b_i are captured on that same edge only) and ignored during RUN.
// busy_o is high for the whole RUN phase. done_o is a one-cycle pulse in
// the cycle p_o first shows the new product; p_o then holds until the next
// DONE entry or a reset.
//
// Timing (sync disabled): start accepted at edge k -> RUN after edges
// k..k+WIDTH, the WIDTH shift-add steps land on edges k+1..k+WIDTH, edge
// k+WIDTH+1 moves the accumulator to p_o and enters DONE.
module mult5_seq_core
  import mult5_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] p_o
);

  // Counter width for this instance (equals CNT_W at the default WIDTH).
  localparam int CW = $clog2(WIDTH + 1);

  logic             start_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;

`ifdef MULT5_INPUT_SYNC_EN
  logic [2*WIDTH:0] sync_d;
  logic [2*WIDTH:0] sync_q;

  assign sync_d = {start_i, a_i, b_i};

  mult5_in_sync #(
    .W (2*WIDTH + 1)
  ) u_in_sync (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .d_i   (sync_d),
    .q_o   (sync_q)
  );

  assign {start_s, a_s, b_s} = sync_q;
`else
  assign start_s = start_i;
  assign a_s     = a_i;
  assign b_s     = b_i;
`endif

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  // Multiplicand zero-extended to accumulator width before shifting, so
  // no partial product is truncated.
  logic [2*WIDTH-1:0] a_ext;
  assign a_ext = {{WIDTH{1'b0}}, a_q};

  // Next-state and datapath: accept, shift-add iterate, publish result.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_s) begin
          a_d     = a_s;
          b_d     = b_s;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == CW'(WIDTH)) begin
          p_d     = acc_q;
          state_d = DONE;
        end else begin
          if (b_q[0]) begin
            acc_d = acc_q + (a_ext << cnt_q);
          end
          b_d   = b_q >> 1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any pending start.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);
  assign p_o    = p_q;

endmodule

// File: tb/tb_mult5_seq_core.sv
// Directed testbench for mult5_seq_core: products, latency, ignored start,
// back-to-back operation and reset behaviour. Honors MULT5_INPUT_SYNC_EN.
module tb_mult5_seq_core;

  localparam int W = 5;
`ifdef MULT5_INPUT_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  // Cycle index of the done pulse, counting the cycle after the start
  // edge as 1: done follows edge k+W+1 (plus synchronizer delay).
  localparam int LAT  = W + 2 + SYNC;
  // Cycle index of the first RUN cycle.
  localparam int RUN0 = 1 + SYNC;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  int errors = 0;
  int checks = 0;

  mult5_seq_core #(
    .WIDTH (W)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .start_i  (start),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .done_o   (done),
    .p_o      (p)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: raise start with operands so the next rising edge accepts them.
  // Returns #1 after that edge (cycle index 1); start is left high.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
  endtask

  // Monitor over a bounded window starting at the current cycle (index 1).
  // At drop_at (if non-zero) start is released and the operands scrambled.
  task automatic monitor(input int ncyc, input int drop_at,
                         output int n_done, output int first_done,
                         output int second_done,
                         output logic [2*W-1:0] p_first,
                         output logic [2*W-1:0] p_second,
                         output int run_p_changes, output logic busy_after);
    logic [2*W-1:0] p_prev;
    n_done        = 0;
    first_done    = 0;
    second_done   = 0;
    p_first       = '0;
    p_second      = '0;
    run_p_changes = 0;
    busy_after    = 1'b0;
    p_prev        = p;
    for (int i = 1; i <= ncyc; i++) begin
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          first_done = i;
          p_first    = p;
        end else if (n_done == 2) begin
          second_done = i;
          p_second    = p;
        end
      end
      if (busy && (p !== p_prev)) run_p_changes++;
      if (!busy) p_prev = p;
      if ((first_done != 0) && (i == first_done + 1)) busy_after = busy;
      if (i == drop_at) begin
        @(negedge clk);
        start = 1'b0;
        a     = ~a;
        b     = ~b;
      end
      if (i < ncyc) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    checks++;
    if (p !== 10'd0) begin
      errors++;
      $display("FAIL reset_p: got %0d expected 0", p);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_products();
    int tv_a[8] = '{31, 0, 1, 31, 1, 16, 6, 21};
    int tv_b[8] = '{31, 27, 1, 1, 31, 16, 7, 10};
    int tv_p[8] = '{961, 0, 1, 31, 31, 256, 42, 210};
    int nd, fd, sd, pc;
    logic [2*W-1:0] p1, p2;
    logic ba;
    for (int t = 0; t < 8; t++) begin
      start_op(W'(tv_a[t]), W'(tv_b[t]));
      monitor(LAT + 4, 1, nd, fd, sd, p1, p2, pc, ba);
      checks++;
      if (nd != 1) begin
        errors++;
        $display("FAIL prod%0d_done_count: got %0d expected 1", t, nd);
      end
      checks++;
      if (fd != LAT) begin
        errors++;
        $display("FAIL prod%0d_latency: got %0d expected %0d", t, fd, LAT);
      end
      checks++;
      if (p1 !== 10'(tv_p[t])) begin
        errors++;
        $display("FAIL prod%0d_value: got %0d expected %0d", t, p1, tv_p[t]);
      end
      checks++;
      if (pc != 0) begin
        errors++;
        $display("FAIL prod%0d_p_stable_in_run: got %0d changes expected 0", t, pc);
      end
      checks++;
      if (p !== 10'(tv_p[t])) begin
        errors++;
        $display("FAIL prod%0d_hold: got %0d expected %0d", t, p, tv_p[t]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int nd, fd, sd, pc;
    logic [2*W-1:0] p1, p2;
    logic ba;
    start_op(5'd17, 5'd3);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    // Index 2: core is in RUN; pulse start with different operands.
    @(negedge clk);
    start = 1'b1;
    a     = 5'd5;
    b     = 5'd5;
    @(posedge clk);
    #1;
    // Window begins at index 3, so the done pulse lands at LAT-2 locally.
    monitor(LAT + 4, 1, nd, fd, sd, p1, p2, pc, ba);
    checks++;
    if (nd != 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d expected 1", nd);
    end
    checks++;
    if (fd != LAT - 2) begin
      errors++;
      $display("FAIL ignore_latency: got %0d expected %0d", fd, LAT - 2);
    end
    checks++;
    if (p1 !== 10'd51) begin
      errors++;
      $display("FAIL ignore_value: got %0d expected 51", p1);
    end
  endtask

  task automatic test_back_to_back();
    int nd, fd, sd, pc;
    logic [2*W-1:0] p1, p2;
    logic ba;
    // Start stays high through the first DONE, so a second run follows
    // directly: accepted on the edge ending DONE, done W+2 cycles later.
    start_op(5'd2, 5'd9);
    monitor(LAT + W + 6, LAT + 1, nd, fd, sd, p1, p2, pc, ba);
    checks++;
    if (nd != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d expected 2", nd);
    end
    checks++;
    if (fd != LAT) begin
      errors++;
      $display("FAIL b2b_first_latency: got %0d expected %0d", fd, LAT);
    end
    checks++;
    if (p1 !== 10'd18) begin
      errors++;
      $display("FAIL b2b_first_value: got %0d expected 18", p1);
    end
    checks++;
    if (ba !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_idle: busy after done got %b expected 1", ba);
    end
    checks++;
    if (sd != LAT + W + 2) begin
      errors++;
      $display("FAIL b2b_second_latency: got %0d expected %0d", sd, LAT + W + 2);
    end
    checks++;
    if (p2 !== 10'd18) begin
      errors++;
      $display("FAIL b2b_second_value: got %0d expected 18", p2);
    end
  endtask

  task automatic test_reset_mid_run();
    int nd, fd, sd, pc;
    logic [2*W-1:0] p1, p2;
    logic ba;
    start_op(5'd31, 5'd31);
    @(negedge clk);
    start = 1'b0;
    repeat (RUN0 + 1) begin
      @(posedge clk);
      #1;
    end
    // Now in the third RUN cycle.
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_busy_before: got %b expected 1", busy);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_busy_after: got %b expected 0", busy);
    end
    checks++;
    if (p !== 10'd0) begin
      errors++;
      $display("FAIL midrun_p_cleared: got %0d expected 0", p);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    monitor(LAT + 4, 0, nd, fd, sd, p1, p2, pc, ba);
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL midrun_no_done: got %0d pulses expected 0", nd);
    end
  endtask

  task automatic test_reset_priority();
    int nd, fd, sd, pc;
    logic [2*W-1:0] p1, p2;
    logic ba;
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    a     = 5'd3;
    b     = 5'd3;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL prio_busy: got %b expected 0", busy);
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    monitor(LAT + 4, 0, nd, fd, sd, p1, p2, pc, ba);
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL prio_no_done: got %0d pulses expected 0", nd);
    end
    // Core recovers and multiplies normally afterwards.
    start_op(5'd6, 5'd7);
    monitor(LAT + 4, 1, nd, fd, sd, p1, p2, pc, ba);
    checks++;
    if (fd != LAT) begin
      errors++;
      $display("FAIL recover_latency: got %0d expected %0d", fd, LAT);
    end
    checks++;
    if (p1 !== 10'd42) begin
      errors++;
      $display("FAIL recover_value: got %0d expected 42", p1);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    test_reset();
    test_products();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
